// File: rtl/mem_byte_sequencer_pkg.sv
// mem_seq_pkg: size encodings, FSM states and beat-count helper for the MEM-stage byte sequencer.
package mem_seq_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
  function automatic logic [2:0] beats(input logic [1:0] size);
    return size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mem_byte_sequencer_load_align_ext.sv
// load_align_ext: right-aligned assembled load bytes -> 32-bit sign/zero-extended result.
module load_align_ext
  import mem_seq_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);
  always_comb
    data_o = size_i == SZ_BYTE ? {{24{signed_i & bytes_i[7]}}, bytes_i[7:0]} :
             size_i == SZ_HALF ? {{16{signed_i & bytes_i[15]}}, bytes_i[15:0]} : bytes_i;
endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits MIPS loads/stores into big-endian byte beats on a byte-wide data_mem,
// stalling the pipeline until the access completes.
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_write_data,
  output logic                  mem_MemWrite,
  output logic                  mem_MemRead,
  input  logic [7:0]            mem_read_data
);
  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d, last_q, last_d, size_q, size_d;
  logic                  write_q, write_d, signed_q, signed_d;
  logic [31:0]           sh_q, sh_d, asm_q, asm_d, rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [7:0]            mwd_q, mwd_d;
  logic                  mwe_q, mwe_d, mre_q, mre_d;
  logic                  legal, stall_c, done_c, err_c;
  logic [31:0]           aligned, asm_nx, ext;
  assign legal = req_size == SZ_BYTE || (req_size == SZ_HALF && !req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] == 2'b00);
  // Store data is left-justified so every beat simply takes the top byte and shifts.
  assign aligned = req_wdata << (6'd32 - {beats(req_size), 3'b000});
  assign asm_nx = {asm_q[23:0], mem_read_data};
  load_align_ext u_ext (
    .bytes_i  (asm_nx),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    size_d = size_q;
    write_d = write_q;
    signed_d = signed_q;
    sh_d = sh_q;
    asm_d = asm_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mwd_d = mwd_q;
    mwe_d = mwe_q;
    mre_d = mre_q;
    stall_c = 1'b0;
    done_c = 1'b0;
    err_c = 1'b0;
    case (state_q)
      IDLE: if (req_valid && legal) begin
        stall_c = 1'b1;
        state_d = XFER;
        cnt_d = 2'd0;
        last_d = req_size == SZ_WORD ? 2'd3 : req_size == SZ_HALF ? 2'd1 : 2'd0;
        size_d = req_size;
        write_d = req_write;
        signed_d = req_signed;
        sh_d = aligned << 8;
        asm_d = 32'd0;
        maddr_d = req_addr;
        mwd_d = aligned[31:24];
        mwe_d = req_write;
        mre_d = !req_write;
      end else err_c = req_valid;
      XFER: begin
        stall_c = 1'b1;
        asm_d = write_q ? asm_q : asm_nx;
        if (cnt_q == last_q) begin
          state_d = RESP;
          mwe_d = 1'b0;
          mre_d = 1'b0;
          rdata_d = write_q ? rdata_q : ext;
        end else begin
          cnt_d = cnt_q + 2'd1;
          maddr_d = maddr_q + ADDR_WIDTH'(1);
          mwd_d = sh_q[31:24];
          sh_d = sh_q << 8;
        end
      end
      default: begin
        done_c = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      signed_q <= 1'b0;
      sh_q <= '0;
      asm_q <= '0;
      rdata_q <= '0;
      maddr_q <= '0;
      mwd_q <= '0;
      mwe_q <= 1'b0;
      mre_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      size_q <= size_d;
      write_q <= write_d;
      signed_q <= signed_d;
      sh_q <= sh_d;
      asm_q <= asm_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mwd_q <= mwd_d;
      mwe_q <= mwe_d;
      mre_q <= mre_d;
    end
  end
  assign stall = stall_c & !reset;
  assign done = done_c & !reset;
  assign err = err_c & !reset;
  assign rdata = rdata_q;
  assign mem_address = maddr_q;
  assign mem_write_data = mwd_q;
  assign mem_MemWrite = mwe_q;
  assign mem_MemRead = mre_q;
endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Sits between the EX/MEM pipeline register and the byte-wide data_mem. This is the MEM-stage access controller.
- Converts MIPS load/store requests (lb, lbu, lh, lhu, lw, sb, sh, sw) into a sequence of 8-bit data_mem accesses, one byte per cycle, in big-endian order.
- Stalls the pipeline while beats are in flight.
- Assembles, sign-extends or zero-extends, and returns 32-bit load data.

Parameters:
- ADDR_WIDTH, 32, width of byte address.
- DATA_WIDTH, 32, width of pipeline-side load/store data. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM-stage request present (MemRead|MemWrite from EX/MEM)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend loads (lb/lh)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data; right-aligned for byte/half
- stall  out  1  hold IF..EX/MEM this cycle
- done  out  1  one-cycle pulse; access complete, rdata valid
- err  out  1  one-cycle pulse; misaligned or reserved size, request dropped
- rdata  out  DATA_WIDTH  load result
- mem_address  out  ADDR_WIDTH  to data_mem address
- mem_write_data  out  8  to data_mem write_data
- mem_MemWrite  out  1  to data_mem MemWrite
- mem_MemRead  out  1  to data_mem MemRead
- mem_read_data  in  8  from data_mem read_data

Behaviour:
- data_mem contract:
  - Write commits on the rising edge while MemWrite=1.
  - read_data is combinational from address while MemRead=1; it is sampled at the edge ending each read beat.
- Reset values: state IDLE; stall=0 (gated while reset=1); done=0; err=0; rdata=0; mem_address=0; mem_write_data=0; mem_MemWrite=0; mem_MemRead=0.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If req_valid and the request is legal: stall=1 combinationally; latch addr/wdata/size/signed/write; beat count N = 1/2/4; load the beat-0 mem_* registers; go to XFER.
  - If req_valid and the request is illegal (size 11; half with addr[0]=1; word with addr[1:0]!=0): err=1 for that cycle; stall=0; no mem strobe; rdata unchanged; stay in IDLE.
- XFER, beat k (0..N-1):
  - mem_* are registered.
  - mem_address = base + k, modulo 2^ADDR_WIDTH.
  - Store: mem_write_data = byte (N-1-k) of the size-wide store value (MSB first); mem_MemWrite=1.
  - Load: mem_MemRead=1; mem_read_data shifts into the assembly register.
  - stall=1.
  - After beat N-1, go to RESP and drop both strobes.
- RESP:
  - done=1 and stall=0; the pipeline advances at this edge.
  - Loads: rdata = assembled value, sign-extended if req_signed else zero-extended, registered at entry to RESP.
  - Stores: rdata unchanged.
  - req_valid is ignored in RESP (it still shows the old request). Next state is IDLE.
- Latency: a request presented in cycle 0 has beats in cycles 1..N and done in cycle N+1. Stall is high in cycles 0..N.
- req_write is authoritative; simultaneous MemRead/MemWrite from upstream is not a special case.
- rdata holds its value until the next load's RESP.
- Reset mid-operation:
  - Asynchronous return to IDLE; strobes drop immediately; no done pulse.
  - Bytes already written stay written; a partial word store is not rolled back.

Decomposition:
- Package mem_seq_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum {IDLE, XFER, RESP};
  - function beats(size) returning 1/2/4.
- Sub-module load_align_ext (combinational): assembled bytes + size + signed -> 32-bit extended result.

Test Plan:
- sw 0xDEADBEEF at 0x10 -> cycles 1-4: mem_address 0x10..0x13, mem_write_data DE,AD,BE,EF, mem_MemWrite=1; done in cycle 5; stall high cycles 0-4.
- lw at 0x10 after the previous store -> 4 read beats; done with rdata=0xDEADBEEF.
- lb 0x12 signed -> rdata 0xFFFFFFBE. lbu 0x12 -> 0x000000BE. lh 0x12 signed -> 0xFFFFBEEF. lhu 0x12 -> 0x0000BEEF.
- sb 0x55 at 0x11 (one beat, done in cycle 2), then lw 0x10 -> rdata 0xDE55BEEF.
- lw at 0x12 and sh at 0x13 -> err pulses one cycle each; stall=0; no strobes; rdata unchanged.
- Assert reset during beat 2 of sw 0x11223344 at 0x20 -> strobes drop asynchronously; stall=0; no done. After release, lw 0x20 completes normally with rdata = 0x1122xxxx (bytes 0x22/0x23 unwritten).
